// File: rtl/sensor_display_hub.sv
// Sensor front end for the seven-segment path: channel/mode select from button edges,
// periodic sampling, per-channel peak tracking, serial double-dabble BCD conversion and level bar.
module sensor_display_hub #(
  parameter int N_CHANNELS     = 4,
  parameter int W              = 16,
  parameter int UPDATE_PERIOD  = 2_700_000,
  parameter int BAR_FULL_SCALE = 2**W - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CHANNELS*W-1:0] ch_value,
  input  logic                    btn_next,
  input  logic                    btn_prev,
  input  logic                    btn_mode,
  input  logic                    btn_hold,
  output logic [31:0]             number,
  output logic [7:0]              dots,
  output logic [7:0]              led_bar,
  output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] channel,
  output logic                    busy
);
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int TW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int SW = $clog2(W + 1);
  localparam int DW = 32 + W;

  typedef enum logic [1:0] {LIVE_DEC, LIVE_HEX, PEAK_DEC} mode_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  logic [N_CHANNELS-1:0][W-1:0] val;
  assign val = ch_value;

  logic [3:0] btn, btn_q, btn_rise;
  assign btn      = {btn_hold, btn_mode, btn_prev, btn_next};
  assign btn_rise = btn & ~btn_q;

  logic [CW-1:0]                channel_q, channel_d;
  mode_e                        mode_q, mode_d;
  logic                         hold_q, hold_d, force_q, restart, tick, req;
  logic [TW-1:0]                tick_q;
  logic [N_CHANNELS-1:0][W-1:0] peak_q;
  logic [W-1:0]                 sample_q, src;
  logic                         hex_q, start_q, busy_q;
  state_e                       state_q;
  logic [SW-1:0]                bit_q;
  logic [DW-1:0]                dd_q, dd_d;
  logic [31:0]                  number_q;
  logic [7:0]                   bar_d, bar_q, dots_q, dots_d;

  always_comb begin
    channel_d = channel_q;
    if (btn_rise[0] && !btn_rise[1])
      channel_d = (channel_q == CW'(N_CHANNELS - 1)) ? '0 : channel_q + 1'b1;
    else if (btn_rise[1] && !btn_rise[0])
      channel_d = (channel_q == '0) ? CW'(N_CHANNELS - 1) : channel_q - 1'b1;
    mode_d = mode_q;
    if (btn_rise[2]) begin
      case (mode_q)
        LIVE_DEC: mode_d = LIVE_HEX;
        LIVE_HEX: mode_d = PEAK_DEC;
        default:  mode_d = LIVE_DEC;
      endcase
    end
  end

  assign hold_d  = hold_q ^ btn_rise[3];
  assign restart = (channel_d != channel_q) || btn_rise[2];
  assign tick    = (tick_q == TW'(UPDATE_PERIOD - 1));
  // Held display ignores both periodic and forced samples.
  assign req     = (tick || force_q) && !hold_q;
  assign src     = (mode_q == PEAK_DEC) ? peak_q[channel_q] : val[channel_q];

  always_comb begin
    dd_d = dd_q;
    for (int k = 0; k < 8; k++)
      if (dd_d[W+4*k +: 4] >= 4'd5) dd_d[W+4*k +: 4] = dd_d[W+4*k +: 4] + 4'd3;
    dd_d = {dd_d[DW-2:0], 1'b0};
  end

  for (genvar k = 0; k < 8; k++) begin : g_bar
    localparam logic [63:0] TK = 64'((longint'(k) + 1) * longint'(BAR_FULL_SCALE) / 8);
    assign bar_d[k] = (64'(sample_q) >= TK);
  end

  always_comb begin
    dots_d    = 8'd1 << channel_q;
    dots_d[7] = hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= btn;
      channel_q <= '0;
      mode_q    <= LIVE_DEC;
      hold_q    <= 1'b0;
      force_q   <= 1'b0;
      tick_q    <= '0;
      peak_q    <= '0;
      sample_q  <= '0;
      hex_q     <= 1'b0;
      start_q   <= 1'b0;
      state_q   <= IDLE;
      bit_q     <= '0;
      dd_q      <= '0;
      number_q  <= '0;
      bar_q     <= '0;
      dots_q    <= 8'h01;
      busy_q    <= 1'b0;
    end else begin
      btn_q     <= btn;
      channel_q <= channel_d;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      dots_q    <= dots_d;
      force_q   <= restart;
      tick_q    <= (restart || tick) ? '0 : tick_q + 1'b1;
      if (tick)
        for (int i = 0; i < N_CHANNELS; i++)
          if (val[i] > peak_q[i]) peak_q[i] <= val[i];
      start_q <= req;
      if (req) begin
        sample_q <= src;
        hex_q    <= (mode_q == LIVE_HEX);
      end
      // A fresh request aborts any conversion so a stale result never reaches the display.
      if (req) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (start_q) begin
        dd_q    <= {32'd0, sample_q};
        bit_q   <= '0;
        state_q <= SHIFT;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            dd_q  <= dd_d;
            bit_q <= bit_q + 1'b1;
            if (bit_q == SW'(W - 1)) state_q <= DONE;
          end
          DONE: begin
            if (!hold_q) begin
              number_q <= hex_q ? 32'(sample_q) : dd_q[DW-1:W];
              bar_q    <= bar_d;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign number  = number_q;
  assign led_bar = bar_q;
  assign dots    = dots_q;
  assign channel = channel_q;
  assign busy    = busy_q;
endmodule

// File: doc/sensor_display_hub.md
Name: sensor_display_hub

Overview:
- Multi-channel sensor front end for the TM1638 display path: selects one of N_CHANNELS sensor values with key edges, samples it at a fixed rate and converts it to BCD with a sequential double-dabble engine.
- Tracks a per-channel peak and drives three outputs: a 32-bit number bus for seven_segment_display, a dots bus, and an 8-LED level bar.
- Sits between the sensor modules (ultrasonic_distance_sensor, rotary_encoder, ...) and seven_segment_display in hackathon_top.

Parameters:
N_CHANNELS, 4, number of sensor inputs; legal range 1..7.
W, 16, width of each sensor value; legal range 1..26, so the value fits in 8 BCD digits.
UPDATE_PERIOD, 2_700_000, clock cycles between samples (10 Hz at 27 MHz); minimum W+3.
BAR_FULL_SCALE, 2**W-1, value at which all 8 LEDs are lit; must be at least 8.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ch_value  in  N_CHANNELS*W  packed sensor values; channel i is bits [i*W +: W]
btn_next  in  1  debounced level; rising edge selects the next channel
btn_prev  in  1  debounced level; rising edge selects the previous channel
btn_mode  in  1  debounced level; rising edge advances the display mode
btn_hold  in  1  debounced level; rising edge toggles display freeze
number  out  32  display value, BCD or hex, to seven_segment_display
dots  out  8  one-hot channel indicator plus hold flag
led_bar  out  8  thermometer bar
channel  out  $clog2(N_CHANNELS) (minimum 1)  current channel index
busy  out  1  high while a conversion is in progress

Behaviour:
- Reset values: channel=0, mode=LIVE_DEC, hold=0, number=0, led_bar=0, dots=8'b0000_0001, busy=0, all peaks=0, tick counter=0. All button edge detectors are reloaded with the current button level, so a button held through reset produces no edge.
- Edge detection: one register per button; an edge is recognised one cycle after the input rises.
- Channel select:
  - next edge: channel+1, wrapping from N_CHANNELS-1 to 0.
  - prev edge: channel-1, wrapping from 0 to N_CHANNELS-1.
  - next and prev edges in the same cycle: channel unchanged, no restart.
  - Any channel change resets the tick counter and forces a sample on the next cycle, aborting any conversion in progress.
- Mode: each btn_mode edge cycles LIVE_DEC -> LIVE_HEX -> PEAK_DEC -> LIVE_DEC. A mode change forces a sample in the same way as a channel change.
- Tick: a free-running counter from 0 to UPDATE_PERIOD-1 produces a tick when it wraps.
- Peaks: on every tick, for every channel i, peak[i] <= max(peak[i], value_i). This happens even while hold is active.
- Sample source: on a tick or a forced sample with hold=0, the source is latched as peak[channel] in PEAK_DEC and as the channel value otherwise. With hold=1, ticks do not latch a sample and number/led_bar are frozen.
- Converter FSM:
  - States: IDLE, SHIFT (W cycles), DONE (1 cycle).
  - SHIFT performs classic double-dabble: add 3 to any BCD nibble that is 5 or more, then shift left one bit per cycle.
  - DONE loads number and led_bar simultaneously.
  - busy=1 in SHIFT and DONE.
  - Latency: number/led_bar update at the W+2nd rising edge after the latch edge.
  - A new latch request arriving in SHIFT or DONE restarts from the new sample; the stale result is never loaded.
- Number format:
  - LIVE_DEC and PEAK_DEC: 8-digit BCD of the sample.
  - LIVE_HEX: the sample zero-extended to 32 bits, loaded at the same DONE edge.
- Bar:
  - Thresholds T_k = ((k+1)*BAR_FULL_SCALE)/8 for k = 0..7, computed at elaboration.
  - led_bar[k] = (sample >= T_k).
  - Values above BAR_FULL_SCALE saturate to 8'hFF.
- dots: dots[channel]=1, dots[7]=hold, all other bits 0. Updates one cycle after a channel or hold change, independent of the converter.
- rst asserted mid-conversion: returns to IDLE, and all outputs take their reset values on that edge.

Test Plan (N_CHANNELS=4, W=16, UPDATE_PERIOD=100, BAR_FULL_SCALE=65535):
1. Reset with btn_next held high -> outputs at reset values, channel stays 0 after release and re-press timing, busy=0.
2. ch0=1234, LIVE_DEC -> number=32'h0000_1234 exactly 18 edges after latch, led_bar=8'h00. Then ch0=65535 -> number=32'h0006_5535, led_bar=8'hFF. Then ch0=40000 -> led_bar=8'h0F.
3. One btn_mode edge (LIVE_HEX), ch0=1234 -> number=32'h0000_04D2.
4. btn_prev edge from channel 0 -> channel=3, dots=8'b0000_1000. next and prev edges in the same cycle -> no change, no busy restart. A next edge during SHIFT -> conversion restarts, old value never appears.
5. ch1 = 100, 5000, 200 on successive ticks, then PEAK_DEC on channel 1 -> number=32'h0000_5000.
6. btn_hold edge -> dots[7]=1. ch0 changes 10 -> 999 for 5 ticks -> number unchanged. A second hold edge -> next tick shows 32'h0000_0999.
